ifu_fetch: RTL

Instruction-fetch stage directly downstream of the PC generator. Takes the current fetch PC and issues one aligned block read of Fetch_Num instructions to instruction memory. It pushes the valid slots of the returned block into an internal instruction buffer and pulses pc_update back to the PC generator when the block is accepted. The buffer drains one instruction per cycle to decode; a redirect (flush) discards in-flight and buffered work.

---
 rtl/ifu_pkg.sv | 24 ++
 rtl/ifu_fetch_if.sv | 28 ++
 rtl/ifu_ibuf.sv | 68 ++++++
 rtl/ifu_fetch.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction-fetch stage: FSM states,
// buffer entry layout and block-offset helper.
package ifu_pkg;

  localparam int FETCH_NUM   = 4;
  localparam int FETCH_BYTES = 4 * FETCH_NUM;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } ifu_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ibuf_entry_t;

  function automatic int off_width(input int fetch_num);
    return $clog2(4 * fetch_num);
  endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Block-read bus between the fetch stage (master) and instruction memory (slave).
interface ifu_fetch_if #(
  parameter int Fetch_Num = 4
);

  logic                     req_valid;
  logic                     req_ready;
  logic [31:0]              req_addr;
  logic                     resp_valid;
  logic [32*Fetch_Num-1:0]  resp_data;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  resp_valid,
    input  resp_data
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output resp_valid,
    output resp_data
  );

endinterface

// File: rtl/ifu_ibuf.sv
// Circular instruction buffer: up to Fetch_Num pushes and one pop per cycle,
// flush clears it with priority over both.
module ifu_ibuf
  import ifu_pkg::*;
#(
  parameter int Fetch_Num  = 4,
  parameter int IBuf_Depth = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          flush,
  input  logic [$clog2(Fetch_Num):0]    push_num,
  input  ibuf_entry_t                   push_data [Fetch_Num],
  input  logic                          pop,
  output logic [$clog2(IBuf_Depth):0]   free_cnt,
  output logic                          valid,
  output ibuf_entry_t                   head
);

  localparam int AW = $clog2(IBuf_Depth);
  localparam int CW = AW + 1;
  localparam int KW = $clog2(Fetch_Num) + 1;

  ibuf_entry_t   mem_q [IBuf_Depth];
  ibuf_entry_t   mem_d [IBuf_Depth];
  logic [CW-1:0] head_q, head_d;
  logic [CW-1:0] tail_q, tail_d;
  logic [CW-1:0] count;

  // Pointers carry a wrap bit, so their difference is the occupancy even when full.
  assign count    = tail_q - head_q;
  assign valid    = (count != '0);
  assign free_cnt = CW'(IBuf_Depth) - count;
  assign head     = mem_q[head_q[AW-1:0]];

  always_comb begin
    mem_d  = mem_q;
    head_d = head_q;
    tail_d = tail_q;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      for (int j = 0; j < Fetch_Num; j++) begin
        if (KW'(j) < push_num) begin
          mem_d[tail_q[AW-1:0] + AW'(j)] = push_data[j];
        end
      end
      tail_d = tail_q + CW'(push_num);
      if (pop && valid) begin
        head_d = head_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q  <= '{default: '0};
      head_q <= '0;
      tail_q <= '0;
    end else begin
      mem_q  <= mem_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: one aligned block read per PC, valid slots pushed into
// the instruction buffer. Define IFU_PERF_EN to build the fetch/stall counters.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter int Fetch_Num  = FETCH_NUM,
  parameter int IBuf_Depth = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       pc,
  input  logic              flush,
  output logic              pc_update,
  ifu_fetch_if.master       mem,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [31:0]       out_pc,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt
);

  localparam int OW = off_width(Fetch_Num);
  localparam int SW = OW - 2;
  localparam int KW = SW + 1;
  localparam int CW = $clog2(IBuf_Depth) + 1;
  localparam int BW = 32 * Fetch_Num;

  ifu_state_e    state_q, state_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic          drop_q, drop_d;
  logic [BW-1:0] held_q, held_d;
  logic [BW-1:0] blk;
  logic [SW-1:0] slot;
  logic [KW-1:0] valid_cnt;
  logic [KW-1:0] push_num;
  logic [CW-1:0] free_cnt;
  logic          fits;
  ibuf_entry_t   push_data [Fetch_Num];
  ibuf_entry_t   head;

  // An unaligned PC only uses the block slots from its own word onwards.
  assign slot      = req_pc_q[OW-1:2];
  assign valid_cnt = KW'(Fetch_Num) - KW'(slot);
  assign fits      = (free_cnt >= CW'(valid_cnt));
  assign blk       = (state_q == HOLD) ? held_q : mem.resp_data;

  assign mem.req_valid = (state_q == REQ);
  assign mem.req_addr  = {req_pc_q[31:OW], {OW{1'b0}}};

  always_comb begin
    state_d   = state_q;
    req_pc_d  = req_pc_q;
    drop_d    = drop_q;
    held_d    = held_q;
    pc_update = 1'b0;
    push_num  = '0;
    case (state_q)
      IDLE: begin
        if (!flush) begin
          state_d  = REQ;
          req_pc_d = pc;
        end
      end
      REQ: begin
        // A request once raised stays up until accepted; a flush only marks it stale.
        if (flush) begin
          drop_d = 1'b1;
        end
        if (mem.req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem.resp_valid) begin
          if (drop_q || flush) begin
            drop_d  = 1'b0;
            state_d = IDLE;
          end else if (fits) begin
            push_num  = valid_cnt;
            pc_update = 1'b1;
            state_d   = IDLE;
          end else begin
            held_d  = mem.resp_data;
            state_d = HOLD;
          end
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end
      HOLD: begin
        if (flush) begin
          state_d = IDLE;
        end else if (fits) begin
          push_num  = valid_cnt;
          pc_update = 1'b1;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    for (int j = 0; j < Fetch_Num; j++) begin
      push_data[j].pc   = req_pc_q + 32'(4 * j);
      push_data[j].inst = blk[32*((int'(slot) + j) % Fetch_Num) +: 32];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      req_pc_q <= '0;
      drop_q   <= 1'b0;
      held_q   <= '0;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
      drop_q   <= drop_d;
      held_q   <= held_d;
    end
  end

  ifu_ibuf #(
    .Fetch_Num  (Fetch_Num),
    .IBuf_Depth (IBuf_Depth)
  ) u_ibuf (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .push_num  (push_num),
    .push_data (push_data),
    .pop       (out_valid && out_ready),
    .free_cnt  (free_cnt),
    .valid     (out_valid),
    .head      (head)
  );

  assign out_inst = head.inst;
  assign out_pc   = head.pc;

`ifdef IFU_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q + {31'd0, pc_update};
    stall_cnt_d = stall_cnt_q + {31'd0, (state_q == HOLD)};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`else
  assign perf_fetch_cnt = '0;
  assign perf_stall_cnt = '0;
`endif

endmodule
